fl_checkpoint_ctrl: RTL and testbench
=====================================

FL_CHECKPOINT_CTRL -- requirements
Module: fl_checkpoint_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_CP, default 4, giving the number of checkpoint slots (power of 2, 2..16).
REQ-002 The block SHALL have parameter CP_LOG, default 2, equal to log2(NUM_CP).
REQ-003 The block SHALL have parameter FL_LOG, default `SIZE_FREE_LIST_LOG, giving the free-list head pointer width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, a synchronous, active-low reset (0 = reset).
REQ-006 The block SHALL have port recoverFlag_i, input, 1, a commit-time full flush.
REQ-007 The block SHALL have port branchValid_i, input, 1, a renamed branch requesting a checkpoint this cycle.
REQ-008 The block SHALL have port freeListHead_i, input, FL_LOG, the speculative free-list head to snapshot.
REQ-009 The block SHALL have port cpTag_o, output, CP_LOG, the checkpoint tag granted to the branch.
REQ-010 The block SHALL have port cpFull_o, output, 1, asserted when no slot is free; the renamer stalls.
REQ-011 The block SHALL have port resolveValid_i, input, 1, a branch resolution from execute.
REQ-012 The block SHALL have port resolveTag_i, input, CP_LOG, the tag being resolved.
REQ-013 The block SHALL have port mispredict_i, input, 1, qualifying the resolution as a mispredict.
REQ-014 The block SHALL have port ctrlVerified_o, output, 1, a one-cycle pulse to the free list marking a resolution.
REQ-015 The block SHALL have port flagRecoverEX_o, output, 1, a one-cycle pulse marking a mispredict recovery.
REQ-016 The block SHALL have port freeListHeadCp_o, output, FL_LOG, the restored head, valid with flagRecoverEX_o.
REQ-017 The block SHALL have port cpCount_o, output, CP_LOG+1, the number of live checkpoints.

Function
REQ-018 The block SHALL keep slots in a circular buffer with oldest pointer, next pointer (CP_LOG bits, wrapping mod NUM_CP) and a live count.
REQ-019 Each slot SHALL hold valid, done and a saved head (FL_LOG bits).
REQ-020 cpTag_o SHALL equal the next pointer combinationally.
REQ-021 cpFull_o SHALL be 1 exactly when count == NUM_CP.
REQ-022 When branchValid_i=1 and cpFull_o=0, the slot at next SHALL be written (valid=1, done=0, head=freeListHead_i), next SHALL increment and count SHALL increase by 1 on that edge.
REQ-023 When branchValid_i=1 and cpFull_o=1, the request SHALL be ignored with no state change.
REQ-024 A correct resolve (resolveValid_i=1, mispredict_i=0) of a valid tag SHALL set done on that slot.
REQ-025 Each cycle, if the oldest slot is valid and done, it SHALL be released (valid=0, oldest+1, count-1); at most one release per cycle.
REQ-026 Release SHALL be in order only: a done slot behind an undone older slot SHALL stay allocated.
REQ-027 A mispredict (resolveValid_i=1, mispredict_i=1) on a valid tag T SHALL invalidate T and every slot younger than T, set next=T and recompute count as (T - oldest) mod NUM_CP.
REQ-028 On a mispredict on tag T, the next edge SHALL register freeListHeadCp_o = saved head of T and pulse flagRecoverEX_o=1 and ctrlVerified_o=1 for exactly one cycle.
REQ-029 A correct resolve SHALL pulse ctrlVerified_o=1 for one cycle with flagRecoverEX_o=0 (one-cycle latency).
REQ-030 A resolve on an invalid tag SHALL be ignored and produce no pulse.
REQ-031 If a mispredict and a branchValid_i occur in the same cycle, the mispredict SHALL win and the allocation SHALL be dropped (the branch is younger and squashed).
REQ-032 If a correct resolve, an allocation and a release occur in the same cycle, all three SHALL take effect, with the count changing by (+alloc - release).
REQ-033 A release and a mispredict in the same cycle SHALL both apply; the count SHALL then be computed from the post-release oldest pointer.
REQ-034 recoverFlag_i=1 SHALL clear all slots (oldest=next=0, count=0), suppress all pulses and override every other input.

Reset
REQ-035 While reset=0 at a clock edge, every slot SHALL be invalidated, oldest=next=0, count=0, and ctrlVerified_o=0, flagRecoverEX_o=0, freeListHeadCp_o=0, cpFull_o=0, cpTag_o=0.
REQ-036 Reset asserted mid-operation SHALL abort any pending pulse; no output pulse SHALL appear in the cycle after reset deasserts.

Verification
REQ-037 The bench SHALL cover: 4 allocations with heads 10,20,30,40 -> tags 0,1,2,3, cpFull_o=1, cpCount_o=4; a 5th request is ignored.
REQ-038 The bench SHALL cover: a mispredict on tag 1 after REQ-037 -> next cycle freeListHeadCp_o=20, flagRecoverEX_o=ctrlVerified_o=1 for 1 cycle, cpCount_o=1, cpTag_o=1.
REQ-039 The bench SHALL cover: 3 live slots, correct resolve of tag 2 then tag 0 -> slot 0 released, slot 2 held until tag 1 resolves, then released on the following cycle.
REQ-040 The bench SHALL cover: the next pointer wrapping 3->0 with an allocation and a release in the same cycle -> cpCount_o unchanged, new tag 0.
REQ-041 The bench SHALL cover: a mispredict coinciding with branchValid_i -> allocation dropped, restored head correct.
REQ-042 The bench SHALL cover: recoverFlag_i or reset=0 with 3 live slots and a pending resolve -> cpCount_o=0, no pulse.

Source files
------------

// File: rtl/fl_checkpoint_ctrl.sv
// fl_checkpoint_ctrl: circular buffer of free-list head checkpoints for in-flight branches.
// Ports:
//   clk, reset          - clock, synchronous active-low reset
//   recoverFlag_i       - commit-time full flush, clears every checkpoint
//   branchValid_i       - renamed branch requests a checkpoint of freeListHead_i
//   cpTag_o, cpFull_o   - tag granted to the branch, no slot free (renamer stalls)
//   resolveValid_i      - branch resolution for resolveTag_i, mispredict_i qualifies it
//   ctrlVerified_o      - one-cycle pulse for every accepted resolution
//   flagRecoverEX_o     - one-cycle pulse for a mispredict, freeListHeadCp_o holds the restored head
//   cpCount_o           - number of live checkpoints
`ifndef SIZE_FREE_LIST_LOG
`define SIZE_FREE_LIST_LOG 7
`endif

module fl_checkpoint_ctrl #(
    parameter int NUM_CP = 4,
    parameter int CP_LOG = 2,
    parameter int FL_LOG = `SIZE_FREE_LIST_LOG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              recoverFlag_i,
    input  logic              branchValid_i,
    input  logic [FL_LOG-1:0] freeListHead_i,
    output logic [CP_LOG-1:0] cpTag_o,
    output logic              cpFull_o,
    input  logic              resolveValid_i,
    input  logic [CP_LOG-1:0] resolveTag_i,
    input  logic              mispredict_i,
    output logic              ctrlVerified_o,
    output logic              flagRecoverEX_o,
    output logic [FL_LOG-1:0] freeListHeadCp_o,
    output logic [CP_LOG:0]   cpCount_o
);
    logic [NUM_CP-1:0] valid_q, valid_d, done_q, done_d;
    logic [FL_LOG-1:0] head_q [NUM_CP];
    logic [CP_LOG-1:0] oldest_q, oldest_d, next_q, next_d, off_t;
    logic [CP_LOG:0]   count_q, count_d;
    logic              cv_q, fr_q;
    logic [FL_LOG-1:0] flh_q;
    logic              hit, mis, rel, alloc;

    assign cpTag_o          = next_q;
    assign cpFull_o         = count_q == (CP_LOG+1)'(NUM_CP);
    assign cpCount_o        = count_q;
    assign ctrlVerified_o   = cv_q;
    assign flagRecoverEX_o  = fr_q;
    assign freeListHeadCp_o = flh_q;

    always_comb begin
        hit   = resolveValid_i & valid_q[resolveTag_i];
        mis   = hit & mispredict_i;
        // a mispredict on the oldest slot keeps it as the restart point rather than releasing it
        rel   = valid_q[oldest_q] & done_q[oldest_q] & ~(mis & resolveTag_i == oldest_q);
        alloc = branchValid_i & ~cpFull_o & ~mis;
        off_t = resolveTag_i - oldest_q;
        valid_d  = valid_q;
        done_d   = done_q;
        oldest_d = oldest_q + CP_LOG'(rel);
        if (hit & ~mispredict_i)
            done_d[resolveTag_i] = 1'b1;
        if (rel)
            valid_d[oldest_q] = 1'b0;
        // age is the distance from oldest, which stays unambiguous even when the buffer is full
        for (int i = 0; i < NUM_CP; i++)
            if (mis && CP_LOG'(CP_LOG'(i) - oldest_q) >= off_t)
                valid_d[i] = 1'b0;
        if (alloc) begin
            valid_d[next_q] = 1'b1;
            done_d[next_q]  = 1'b0;
        end
        next_d  = mis ? resolveTag_i : next_q + CP_LOG'(alloc);
        count_d = mis ? {1'b0, CP_LOG'(resolveTag_i - oldest_d)}
                      : count_q + (CP_LOG+1)'(alloc) - (CP_LOG+1)'(rel);
    end

    always_ff @(posedge clk) begin
        if (!reset || recoverFlag_i) begin
            valid_q  <= '0;
            done_q   <= '0;
            oldest_q <= '0;
            next_q   <= '0;
            count_q  <= '0;
            cv_q     <= 1'b0;
            fr_q     <= 1'b0;
            flh_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            done_q   <= done_d;
            oldest_q <= oldest_d;
            next_q   <= next_d;
            count_q  <= count_d;
            cv_q     <= hit;
            fr_q     <= mis;
            if (mis)
                flh_q <= head_q[resolveTag_i];
            if (alloc)
                head_q[next_q] <= freeListHead_i;
        end
    end
endmodule

// File: tb/tb_fl_checkpoint_ctrl.sv
// tb_fl_checkpoint_ctrl: table-driven directed check of the checkpoint controller.
module tb_fl_checkpoint_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       recoverFlag_i = 1'b0;
    logic       branchValid_i = 1'b0;
    logic [6:0] freeListHead_i = '0;
    logic [1:0] cpTag_o;
    logic       cpFull_o;
    logic       resolveValid_i = 1'b0;
    logic [1:0] resolveTag_i = '0;
    logic       mispredict_i = 1'b0;
    logic       ctrlVerified_o;
    logic       flagRecoverEX_o;
    logic [6:0] freeListHeadCp_o;
    logic [2:0] cpCount_o;
    int         tests = 0;
    int         fails = 0;

    fl_checkpoint_ctrl #(.NUM_CP(4), .CP_LOG(2), .FL_LOG(7)) dut (
        .clk(clk), .reset(reset), .recoverFlag_i(recoverFlag_i),
        .branchValid_i(branchValid_i), .freeListHead_i(freeListHead_i),
        .cpTag_o(cpTag_o), .cpFull_o(cpFull_o),
        .resolveValid_i(resolveValid_i), .resolveTag_i(resolveTag_i),
        .mispredict_i(mispredict_i), .ctrlVerified_o(ctrlVerified_o),
        .flagRecoverEX_o(flagRecoverEX_o), .freeListHeadCp_o(freeListHeadCp_o),
        .cpCount_o(cpCount_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, rec, bv;
        logic [6:0] head;
        logic       rv;
        logic [1:0] tag;
        logic       mis;
        logic [1:0] e_tag;
        logic       e_full;
        logic [2:0] e_cnt;
        logic       e_cv, e_fr;
        logic [6:0] e_flh;
    } vec_t;

    vec_t v[35];

    function automatic vec_t mk(int rst, int rec, int bv, int head, int rv, int tag, int mis,
                                int et, int ef, int ec, int ecv, int efr, int eflh);
        vec_t r;
        r.rst = 1'(rst); r.rec = 1'(rec); r.bv = 1'(bv); r.head = 7'(head);
        r.rv = 1'(rv); r.tag = 2'(tag); r.mis = 1'(mis);
        r.e_tag = 2'(et); r.e_full = 1'(ef); r.e_cnt = 3'(ec);
        r.e_cv = 1'(ecv); r.e_fr = 1'(efr); r.e_flh = 7'(eflh);
        return r;
    endfunction

    task automatic chk(input string name, input int row, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        @(negedge clk);
        reset = x.rst; recoverFlag_i = x.rec; branchValid_i = x.bv; freeListHead_i = x.head;
        resolveValid_i = x.rv; resolveTag_i = x.tag; mispredict_i = x.mis;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input int row, input vec_t x);
        chk("cpTag", row, int'(cpTag_o), int'(x.e_tag));
        chk("cpFull", row, int'(cpFull_o), int'(x.e_full));
        chk("cpCount", row, int'(cpCount_o), int'(x.e_cnt));
        chk("ctrlVerified", row, int'(ctrlVerified_o), int'(x.e_cv));
        chk("flagRecoverEX", row, int'(flagRecoverEX_o), int'(x.e_fr));
        chk("freeListHeadCp", row, int'(freeListHeadCp_o), int'(x.e_flh));
    endtask

    initial begin
        //          rst rec bv head rv tag mis | tag full cnt cv fr flh
        v[0]  = mk(1, 0, 1, 10, 0, 0, 0,  1, 0, 1, 0, 0, 0);
        v[1]  = mk(1, 0, 1, 20, 0, 0, 0,  2, 0, 2, 0, 0, 0);
        v[2]  = mk(1, 0, 1, 30, 0, 0, 0,  3, 0, 3, 0, 0, 0);
        v[3]  = mk(1, 0, 1, 40, 0, 0, 0,  0, 1, 4, 0, 0, 0);
        v[4]  = mk(1, 0, 1, 50, 0, 0, 0,  0, 1, 4, 0, 0, 0);
        v[5]  = mk(1, 0, 0, 0,  1, 1, 1,  1, 0, 1, 1, 1, 20);
        v[6]  = mk(1, 0, 0, 0,  0, 0, 0,  1, 0, 1, 0, 0, 20);
        v[7]  = mk(1, 0, 1, 21, 0, 0, 0,  2, 0, 2, 0, 0, 20);
        v[8]  = mk(1, 0, 1, 31, 0, 0, 0,  3, 0, 3, 0, 0, 20);
        v[9]  = mk(1, 0, 0, 0,  1, 2, 0,  3, 0, 3, 1, 0, 20);
        v[10] = mk(1, 0, 0, 0,  1, 0, 0,  3, 0, 3, 1, 0, 20);
        v[11] = mk(1, 0, 0, 0,  0, 0, 0,  3, 0, 2, 0, 0, 20);
        v[12] = mk(1, 0, 0, 0,  0, 0, 0,  3, 0, 2, 0, 0, 20);
        v[13] = mk(1, 0, 0, 0,  1, 1, 0,  3, 0, 2, 1, 0, 20);
        v[14] = mk(1, 0, 0, 0,  0, 0, 0,  3, 0, 1, 0, 0, 20);
        v[15] = mk(1, 0, 1, 41, 0, 0, 0,  0, 0, 1, 0, 0, 20);
        v[16] = mk(1, 0, 1, 51, 0, 0, 0,  1, 0, 2, 0, 0, 20);
        v[17] = mk(1, 0, 1, 61, 1, 0, 1,  0, 0, 1, 1, 1, 51);
        v[18] = mk(1, 0, 0, 0,  0, 0, 0,  0, 0, 1, 0, 0, 51);
        v[19] = mk(1, 0, 0, 0,  1, 2, 1,  0, 0, 1, 0, 0, 51);
        v[20] = mk(1, 0, 1, 71, 0, 0, 0,  1, 0, 2, 0, 0, 51);
        v[21] = mk(1, 0, 1, 81, 1, 3, 0,  2, 0, 3, 1, 0, 51);
        v[22] = mk(1, 0, 1, 91, 1, 0, 0,  3, 0, 3, 1, 0, 51);
        v[23] = mk(1, 0, 0, 0,  1, 1, 1,  1, 0, 0, 1, 1, 81);
        v[24] = mk(1, 0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 0, 81);
        v[25] = mk(1, 0, 1, 11, 0, 0, 0,  2, 0, 1, 0, 0, 81);
        v[26] = mk(1, 0, 1, 12, 0, 0, 0,  3, 0, 2, 0, 0, 81);
        v[27] = mk(1, 0, 1, 13, 0, 0, 0,  0, 0, 3, 0, 0, 81);
        v[28] = mk(1, 1, 1, 14, 1, 1, 1,  0, 0, 0, 0, 0, 0);
        v[29] = mk(1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0);
        v[30] = mk(1, 0, 1, 1,  0, 0, 0,  1, 0, 1, 0, 0, 0);
        v[31] = mk(1, 0, 1, 2,  0, 0, 0,  2, 0, 2, 0, 0, 0);
        v[32] = mk(1, 0, 1, 3,  0, 0, 0,  3, 0, 3, 0, 0, 0);
        v[33] = mk(0, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0, 0, 0);
        v[34] = mk(1, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_tag", -1, int'(cpTag_o), 0);
        chk("reset_full", -1, int'(cpFull_o), 0);
        chk("reset_count", -1, int'(cpCount_o), 0);
        chk("reset_cv", -1, int'(ctrlVerified_o), 0);
        chk("reset_fr", -1, int'(flagRecoverEX_o), 0);
        chk("reset_flh", -1, int'(freeListHeadCp_o), 0);

        for (int i = 0; i < 35; i++) begin
            drive(v[i]);
            check_all(i, v[i]);
        end

        // full buffer, mispredict on the oldest tag: everything squashed, head of slot 0 restored
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            drive(mk(1, 0, 1, 5 + i, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("seq_full", 100, int'(cpFull_o), 1);
        chk("seq_full_count", 100, int'(cpCount_o), 4);
        drive(mk(1, 0, 1, 9, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        chk("seq_oldest_mis_count", 101, int'(cpCount_o), 0);
        chk("seq_oldest_mis_tag", 101, int'(cpTag_o), 0);
        chk("seq_oldest_mis_fr", 101, int'(flagRecoverEX_o), 1);
        chk("seq_oldest_mis_flh", 101, int'(freeListHeadCp_o), 5);
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("seq_pulse_end_fr", 102, int'(flagRecoverEX_o), 0);
        chk("seq_pulse_end_cv", 102, int'(ctrlVerified_o), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
